psum_drain_acc: RTL and testbench

- Consumer at the bottom of one systolic-array column.
- Accepts the 24-bit unsigned partial sums that leave the last MAC of the column, one per row index, once per K-tile.
- Accumulates them across num_tiles K-tiles in a DEPTH-entry buffer, then drains the final sums to the result writer over a valid/ready interface.

---
 rtl/psum_drain_acc.sv | 138 +++++++++++++
 tb/tb_psum_drain_acc.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_acc.sv
// psum_drain_acc: accumulates per-row partial sums from one systolic column over K-tiles, then drains them.
// Optional macro ACC_SAT_EN: unsigned saturating accumulation instead of modulo wrap.
`default_nettype none

module psum_drain_acc #(
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 8,
  parameter int TILE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TILE_W-1:0]        num_tiles,
  output logic                     busy,
  input  logic                     psum_valid,
  input  logic [PSUM_W-1:0]        psum_in,
  output logic                     psum_ready,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_data,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  input  logic                     out_ready,
  output logic                     done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic              done_q, done_d;

  logic [ACC_W-1:0]  mem_q [DEPTH];
  logic [ACC_W-1:0]  w_cur, w_psum_ext, w_add, w_wdata;
  logic              w_accept;

  assign w_accept   = (state_q == S_ACCUM) && psum_valid;
  assign w_cur      = mem_q[row_q];
  assign w_psum_ext = ACC_W'(psum_in);

`ifdef ACC_SAT_EN
  logic [ACC_W:0] w_sum;
  assign w_sum = {1'b0, w_cur} + {1'b0, w_psum_ext};
  assign w_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_add = w_cur + w_psum_ext;
`endif

  // The first tile overwrites, so stale contents from a previous job never leak in.
  assign w_wdata = (tile_q == '0) ? w_psum_ext : w_add;

  always_ff @(posedge clk) begin
    if (w_accept) mem_q[row_q] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (num_tiles != '0)) begin
          ntiles_d = num_tiles;
          row_d    = '0;
          tile_d   = '0;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (tile_q == ntiles_q - TILE_W'(1)) begin
              tile_d  = '0;
              state_d = S_DRAIN;
            end else begin
              tile_d = tile_q + TILE_W'(1);
            end
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_ACCUM) || (state_q == S_DRAIN);
    psum_ready = (state_q == S_ACCUM);
    out_valid  = (state_q == S_DRAIN);
    out_data   = '0;
    out_idx    = '0;
    done       = done_q;
    if (state_q == S_DRAIN) begin
      out_data = mem_q[row_q];
      out_idx  = row_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psum_drain_acc.sv
// Testbench for psum_drain_acc: a 32-bit and a 24-bit instance run in lockstep against a sum-per-row model.
`default_nettype none

module tb_psum_drain_acc;

  localparam int DEPTH  = 8;
  localparam int PSUM_W = 24;
  localparam int ACC_W  = 32;
  localparam int TILE_W = 8;
  localparam int IW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              psum_valid = 1'b0;
  logic [PSUM_W-1:0] psum_in = '0;
  logic              out_ready = 1'b1;

  logic              busy, psum_ready, out_valid, done;
  logic [ACC_W-1:0]  out_data;
  logic [IW-1:0]     out_idx;
  logic              busy2, psum_ready2, out_valid2, done2;
  logic [23:0]       out_data2;
  logic [IW-1:0]     out_idx2;

  psum_drain_acc #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .TILE_W(TILE_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .busy(busy),
    .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(psum_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .done(done));

  psum_drain_acc #(.PSUM_W(PSUM_W), .ACC_W(24), .DEPTH(DEPTH), .TILE_W(TILE_W)) u_dut24 (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .busy(busy2),
    .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(psum_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_idx(out_idx2),
    .out_ready(out_ready), .done(done2));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [PSUM_W-1:0] psq[$];
  longint unsigned   got_d[$];
  longint unsigned   got_d2[$];
  int                got_i[$];
  int                drain_cycles;
  bit                first_valid;
  int                stall_bad;

  // Final value of a row: the plain sum over tiles, then wrapped or clamped to the accumulator width.
  function automatic longint unsigned expv(int r, int nt, int w);
    longint unsigned t = 0;
    longint unsigned mx = (64'd1 << w) - 1;
    for (int k = 0; k < nt; k++) t += longint'(psq[k*DEPTH + r]);
`ifdef ACC_SAT_EN
    return (t > mx) ? mx : t;
`else
    return t & mx;
`endif
  endfunction

  task automatic do_start(input int nt);
    @(negedge clk);
    start = 1'b1; num_tiles = TILE_W'(nt);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: alternate, 2: random. glitch_at: cycle to pulse start while busy.
  task automatic feed(input int mode, input int glitch_at);
    int acc = 0;
    int cyc = 0;
    while (acc < psq.size() && cyc < 2000) begin
      case (mode)
        0:       psum_valid = 1'b1;
        1:       psum_valid = (cyc % 2 == 0);
        default: psum_valid = 1'($urandom_range(0, 1));
      endcase
      psum_in = psq[acc];
      if (cyc == glitch_at) begin start = 1'b1; num_tiles = 8'd7; end
      else start = 1'b0;
      if (psum_valid && psum_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    psum_valid = 1'b0; start = 1'b0;
    if (acc < psq.size()) begin
      vectors++; miscompares++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", acc, psq.size());
    end
  endtask

  task automatic drain(input int stall_idx, input int stall_n);
    int stalls = 0;
    logic [ACC_W-1:0] hd = '0;
    logic [IW-1:0]    hi = '0;
    got_d.delete(); got_d2.delete(); got_i.delete();
    drain_cycles = 0; stall_bad = 0;
    first_valid = out_valid;
    while (got_d.size() < DEPTH && drain_cycles < 2000) begin
      out_ready = 1'b1;
      if (out_valid && int'(out_idx) == stall_idx && stalls < stall_n) begin
        if (stalls > 0 && (out_data !== hd || out_idx !== hi)) stall_bad++;
        hd = out_data; hi = out_idx; out_ready = 1'b0; stalls++;
      end
      if (out_valid && out_ready) begin
        if (stall_n > 0 && int'(out_idx) == stall_idx && out_data !== hd) stall_bad++;
        got_d.push_back(longint'(out_data));
        got_d2.push_back(longint'(out_data2));
        got_i.push_back(int'(out_idx));
      end
      drain_cycles++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (got_d.size() < DEPTH) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout got=%0d required=%0d", got_d.size(), DEPTH);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    vectors++;
    if ({busy, psum_ready, out_valid, done, out_data, out_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b rdy=%b ov=%b done=%b data=%h idx=%0d required all 0",
               busy, psum_ready, out_valid, done, out_data, out_idx);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    psq.delete();
    for (int i = 1; i <= DEPTH; i++) psq.push_back(PSUM_W'(i));
    do_start(1);
    feed(0, -1);
    drain(-1, 0);
    vectors++;
    if (first_valid !== 1'b1 || drain_cycles != DEPTH) begin
      miscompares++;
      $display("FAIL basic_latency got first_valid=%b cycles=%0d required 1/%0d", first_valid, drain_cycles, DEPTH);
    end
    for (int r = 0; r < got_d.size(); r++) begin
      vectors++;
      if (got_d[r] !== longint'(r + 1) || got_i[r] != r) begin
        miscompares++;
        $display("FAIL basic_row%0d got data=%0d idx=%0d required data=%0d idx=%0d", r, got_d[r], got_i[r], r + 1, r);
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done got done=%b busy=%b required 1/0", done, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse got done=%b required 0", done);
    end
  endtask

  task automatic test_multi_tile;
    psq.delete();
    for (int i = 0; i < 3*DEPTH; i++) psq.push_back(24'hFFFFFF);
    do_start(3);
    feed(0, -1);
    drain(-1, 0);
    for (int r = 0; r < got_d.size(); r++) begin
      vectors++;
      if (got_d[r] !== 64'h02FFFFFD || got_d[r] !== expv(r, 3, ACC_W)) begin
        miscompares++;
        $display("FAIL multi_row%0d got %h required 02fffffd", r, got_d[r]);
      end
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 6; j++) begin
      int nt = $urandom_range(1, 4);
      psq.delete();
      for (int i = 0; i < nt*DEPTH; i++) psq.push_back(PSUM_W'($urandom));
      do_start(nt);
      feed(2, -1);
      drain(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 2)));
      for (int r = 0; r < got_d.size(); r++) begin
        vectors++;
        if (got_d[r] !== expv(r, nt, ACC_W) || got_d2[r] !== expv(r, nt, 24) || got_i[r] != r) begin
          miscompares++;
          $display("FAIL random_job%0d_row%0d got %h/%h idx=%0d required %h/%h idx=%0d", j, r,
                   got_d[r], got_d2[r], got_i[r], expv(r, nt, ACC_W), expv(r, nt, 24), r);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    psq.delete();
    for (int i = 0; i < 2*DEPTH; i++) psq.push_back(PSUM_W'(100 + 7*i));
    do_start(2);
    feed(1, -1);
    drain(2, 3);
    vectors++;
    if (stall_bad != 0 || drain_cycles != DEPTH + 3) begin
      miscompares++;
      $display("FAIL bp_stall got changes=%0d cycles=%0d required 0/%0d", stall_bad, drain_cycles, DEPTH + 3);
    end
    for (int r = 0; r < got_d.size(); r++) begin
      vectors++;
      if (got_d[r] !== expv(r, 2, ACC_W) || got_i[r] != r) begin
        miscompares++;
        $display("FAIL bp_row%0d got %0d idx=%0d required %0d idx=%0d", r, got_d[r], got_i[r], expv(r, 2, ACC_W), r);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_control;
    do_start(0);
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || psum_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ctl_zero_tiles got busy=%b rdy=%b required 0/0", busy, psum_ready);
    end
    psq.delete();
    for (int i = 0; i < DEPTH; i++) psq.push_back(PSUM_W'(50 + i));
    do_start(1);
    feed(0, 3);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ctl_start_ignored got out_valid=%b required 1", out_valid);
    end
    drain(-1, 0);
    for (int r = 0; r < got_d.size(); r++) begin
      vectors++;
      if (got_d[r] !== longint'(50 + r)) begin
        miscompares++;
        $display("FAIL ctl_row%0d got %0d required %0d", r, got_d[r], 50 + r);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    psq.delete();
    for (int i = 0; i < 5; i++) psq.push_back(PSUM_W'(900 + i));
    do_start(1);
    feed(0, -1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, psum_ready, out_valid, done, out_data, out_idx} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async got busy=%b rdy=%b ov=%b done=%b required all 0", busy, psum_ready, out_valid, done);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_idle%0d got ov=%b done=%b busy=%b required 0", c, out_valid, done, busy);
      end
    end
    psq.delete();
    for (int i = 10; i <= 17; i++) psq.push_back(PSUM_W'(i));
    do_start(1);
    feed(0, -1);
    drain(-1, 0);
    for (int r = 0; r < got_d.size(); r++) begin
      vectors++;
      if (got_d[r] !== longint'(10 + r)) begin
        miscompares++;
        $display("FAIL rstmid_row%0d got %0d required %0d", r, got_d[r], 10 + r);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    psq.delete();
    for (int i = 0; i < DEPTH; i++) psq.push_back(PSUM_W'(3*i + 1));
    do_start(1);
    feed(0, -1);
    drain(-1, 0);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done got %b required 1", done);
    end
    start = 1'b1; num_tiles = 8'd1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart got busy=%b required 1", busy);
    end
    psq.delete();
    for (int i = 0; i < DEPTH; i++) psq.push_back(PSUM_W'(1000 - i));
    feed(0, -1);
    drain(-1, 0);
    for (int r = 0; r < got_d.size(); r++) begin
      vectors++;
      if (got_d[r] !== longint'(1000 - r)) begin
        miscompares++;
        $display("FAIL b2b_row%0d got %0d required %0d", r, got_d[r], 1000 - r);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_width24;
    longint unsigned want;
`ifdef ACC_SAT_EN
    want = 64'hFFFFFF;
`else
    want = 64'hFFFFFE;
`endif
    psq.delete();
    for (int i = 0; i < 2*DEPTH; i++) psq.push_back(24'hFFFFFF);
    do_start(2);
    feed(0, -1);
    vectors++;
    if (out_valid2 !== 1'b1 || out_idx2 !== '0 || busy2 !== 1'b1 || psum_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL w24_drain_entry got ov=%b idx=%0d busy=%b rdy=%b required 1/0/1/0",
               out_valid2, out_idx2, busy2, psum_ready2);
    end
    drain(-1, 0);
    for (int r = 0; r < got_d2.size(); r++) begin
      vectors++;
      if (got_d2[r] !== want || got_d2[r] !== expv(r, 2, 24)) begin
        miscompares++;
        $display("FAIL w24_row%0d got %h required %h", r, got_d2[r], want);
      end
    end
    vectors++;
    if (done2 !== 1'b1) begin
      miscompares++;
      $display("FAIL w24_done got %b required 1", done2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_tile();
    test_backpressure();
    test_control();
    test_reset_mid();
    test_back_to_back();
    test_width24();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
